// File: rtl/key_entry_ctrl.sv
//------------------------------------------------------------------------------
// Module      : key_entry_ctrl
// Description : Debounces keypad scanner strobes and turns them into BCD digit
//               entry, operator events with a latched operand, and clear.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module key_entry_ctrl #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         KeyRead,
  input  logic [3:0]                   BCDKey,
  input  logic                         accept_en,
  output logic [4*DIGITS-1:0]          entry,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         key_valid,
  output logic                         op_valid,
  output logic [2:0]                   op_code,
  output logic [4*DIGITS-1:0]          op_operand,
  output logic                         clear_pulse,
  output logic                         overflow
);

  localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int c_DC_W  = $clog2(DIGITS+1);
  localparam logic [c_CNT_W-1:0] c_CNT_TERM = c_CNT_W'(DEBOUNCE_CYCLES-1);
  localparam logic [c_DC_W-1:0]  c_DC_FULL  = c_DC_W'(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DB_PRESS = 2'd1,
    S_HELD     = 2'd2,
    S_DB_REL   = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]           r_key_cap, w_key_cap_nxt;
  logic                 w_accept;
  logic                 r_kr_meta, r_kr_s;
  logic [3:0]           r_code_meta, r_code_s;
  logic [4*DIGITS-1:0]  w_entry_shift;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_kr_meta   <= 1'b0;
      r_kr_s      <= 1'b0;
      r_code_meta <= 4'd0;
      r_code_s    <= 4'd0;
    end else begin
      r_kr_meta   <= KeyRead;
      r_kr_s      <= r_kr_meta;
      r_code_meta <= BCDKey;
      r_code_s    <= r_code_meta;
    end
  end

  // Starting in DB_REL means a key already down at reset must be released first.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_DB_REL;
      r_cnt     <= '0;
      r_key_cap <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_key_cap <= w_key_cap_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_key_cap_nxt = r_key_cap;
    w_accept      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_kr_s && accept_en) begin
          w_key_cap_nxt = r_code_s;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_DB_PRESS;
        end
      end
      S_DB_PRESS: begin
        if (!r_kr_s || (r_code_s != r_key_cap)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_CNT_TERM) begin
          w_accept    = 1'b1;
          w_state_nxt = S_HELD;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!r_kr_s) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DB_REL;
        end
      end
      S_DB_REL: begin
        if (r_kr_s) begin
          w_state_nxt = S_HELD;
        end else if (r_cnt == c_CNT_TERM) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  generate
    if (DIGITS > 1) begin : g_shift_multi
      assign w_entry_shift = {entry[4*DIGITS-5:0], r_key_cap};
    end else begin : g_shift_single
      assign w_entry_shift = r_key_cap;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      entry       <= '0;
      digit_count <= '0;
      key_valid   <= 1'b0;
      op_valid    <= 1'b0;
      op_code     <= 3'd0;
      op_operand  <= '0;
      clear_pulse <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      op_valid    <= 1'b0;
      clear_pulse <= 1'b0;
      if (w_accept) begin
        key_valid <= 1'b1;
        if (r_key_cap <= 4'd9) begin
          if (digit_count == c_DC_FULL) begin
            overflow <= 1'b1;
          end else if (!((r_key_cap == 4'd0) && (digit_count == '0))) begin
            entry       <= w_entry_shift;
            digit_count <= digit_count + 1'b1;
          end
        end else if (r_key_cap == 4'd15) begin
          clear_pulse <= 1'b1;
          entry       <= '0;
          digit_count <= '0;
          overflow    <= 1'b0;
        end else begin
          // Keys 10..14 have low bits 2..6, so subtracting 2 mod 8 yields 0..4.
          op_valid    <= 1'b1;
          op_code     <= r_key_cap[2:0] - 3'd2;
          op_operand  <= entry;
          entry       <= '0;
          digit_count <= '0;
          overflow    <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire
